// File: rtl/dmem_responder.sv
// dmem_responder: word-organised data RAM behind a req/resp handshake with programmable wait states
module dmem_responder #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        busy,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = WAIT_CYCLES > 1 ? $clog2(WAIT_CYCLES) : 1;
  localparam bit ZW = WAIT_CYCLES == 0;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state_q;
  logic [CW-1:0] cnt_q;
  logic wr_q, err_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0] be_q;
  logic [31:0] mem [DEPTH];
  logic commit, c_wr, c_err;
  logic [31:0] c_addr, c_wdata;
  logic [3:0] c_be;
  logic [AW-1:0] c_idx;
  assign c_wr    = ZW ? req_write : wr_q;
  assign c_addr  = ZW ? req_addr  : addr_q;
  assign c_wdata = ZW ? req_wdata : wdata_q;
  assign c_be    = ZW ? req_be    : be_q;
  assign c_idx   = c_addr[AW+1:2];
  assign c_err   = (|c_addr[1:0]) || ({2'b0, c_addr[31:2]} >= 32'(DEPTH));
  assign commit  = rst_n && (ZW ? (state_q == IDLE && req_valid) : (state_q == WAIT && cnt_q == '0));
  assign busy       = state_q != IDLE;
  assign resp_valid = state_q == RESP;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  always_ff @(posedge clk)
    if (commit && c_wr && !c_err)
      for (int i = 0; i < 4; i++)
        if (c_be[i]) mem[c_idx][8*i +: 8] <= c_wdata[8*i +: 8];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          wr_q    <= req_write;
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
          be_q    <= req_be;
          cnt_q   <= CW'(WAIT_CYCLES - 1);
          state_q <= ZW ? RESP : WAIT;
        end
        WAIT: if (cnt_q == '0) state_q <= RESP;
              else cnt_q <= cnt_q - 1'b1;
        default: state_q <= IDLE;
      endcase
      if (commit) begin
        err_q   <= c_err;
        rdata_q <= (c_err || c_wr) ? '0 : mem[c_idx];
      end
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for dmem_responder (WAIT_CYCLES=2 and WAIT_CYCLES=0 instances)
module tb_dmem_responder;
  logic clk, rst_n;
  logic req_valid, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0] req_be;
  logic busy, resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic z_req_valid, z_req_write;
  logic [31:0] z_req_addr, z_req_wdata;
  logic [3:0] z_req_be;
  logic z_busy, z_resp_valid, z_resp_err;
  logic [31:0] z_resp_rdata;
  int checks, errors;
  logic [32:0] sb [$];
  logic [31:0] model [0:1023];

  dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .busy(busy),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(z_req_valid), .req_write(z_req_write),
    .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_be(z_req_be), .busy(z_busy),
    .resp_valid(z_resp_valid), .resp_rdata(z_resp_rdata), .resp_err(z_resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Full access on the WAIT_CYCLES=2 instance; intrude rewrites the request fields while busy
  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, input string nm, input bit intrude);
    logic e;
    logic [32:0] exp, got;
    int lat;
    e = (a[1:0] != 2'b0) || (a[31:2] >= 30'd1024);
    if (e) exp = {1'b1, 32'h0};
    else if (w) begin
      for (int i = 0; i < 4; i++) if (be[i]) model[a[11:2]][8*i +: 8] = d[8*i +: 8];
      exp = '0;
    end else exp = {1'b0, model[a[11:2]]};
    sb.push_back(exp);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL %s idle_before: busy=%b required 0", nm, busy); end
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_be = be;
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (intrude && lat == 1) begin
        req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h5555_5555; req_be = 4'hf;
      end
      if (!resp_valid) begin
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL %s busy_wait: busy=%b required 1 at %0d", nm, busy, lat); end
      end
    end while (!resp_valid && lat < 10);
    got = sb.pop_front();
    checks++;
    if (resp_valid !== 1'b1) begin
      errors++; $display("FAIL %s timeout: no resp_valid within %0d cycles", nm, lat);
    end else begin
      checks++;
      if (lat != 3) begin errors++; $display("FAIL %s latency: got %0d required 3", nm, lat); end
      checks++;
      if ({resp_err, resp_rdata} !== got || busy !== 1'b1)
        begin errors++; $display("FAIL %s resp: err=%b rdata=%h busy=%b required err=%b rdata=%h busy=1", nm, resp_err, resp_rdata, busy, got[32], got[31:0]); end
    end
    req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0 || busy !== 1'b0 || {resp_err, resp_rdata} !== got)
      begin errors++; $display("FAIL %s after: valid=%b busy=%b err=%b rdata=%h required 0 0 %b %h", nm, resp_valid, busy, resp_err, resp_rdata, got[32], got[31:0]); end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_be = 0;
    z_req_valid = 0; z_req_write = 0; z_req_addr = 0; z_req_wdata = 0; z_req_be = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, resp_valid, resp_err, resp_rdata, z_busy, z_resp_valid, z_resp_err, z_resp_rdata} !== '0)
      begin errors++; $display("FAIL reset: busy=%b valid=%b err=%b rdata=%h z=%b%b%b%h required all 0", busy, resp_valid, resp_err, resp_rdata, z_busy, z_resp_valid, z_resp_err, z_resp_rdata); end
    rst_n = 1'b1;
  endtask

  task automatic test_store_load;
    access(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hf, "st_full", 1'b0);
    access(1'b0, 32'h10, 32'h0, 4'h0, "ld_full", 1'b0);
    access(1'b1, 32'h10, 32'h0000_00AA, 4'h1, "st_byte0", 1'b0);
    access(1'b0, 32'h10, 32'h0, 4'h0, "ld_byte0", 1'b0);
    access(1'b1, 32'h10, 32'h1122_3344, 4'ha, "st_be1010", 1'b0);
    access(1'b0, 32'h10, 32'h0, 4'h0, "ld_be1010", 1'b0);
    access(1'b1, 32'h10, 32'hFFFF_FFFF, 4'h0, "st_be0", 1'b0);
    access(1'b0, 32'h10, 32'h0, 4'h0, "ld_be0", 1'b0);
    access(1'b1, 32'hFFC, 32'h0BAD_CAFE, 4'hf, "st_last", 1'b0);
    access(1'b0, 32'hFFC, 32'h0, 4'h0, "ld_last", 1'b0);
  endtask

  task automatic test_errors;
    access(1'b1, 32'h0, 32'h600D_0000, 4'hf, "st_w0", 1'b0);
    access(1'b0, 32'h12, 32'h0, 4'h0, "ld_misalign", 1'b0);
    access(1'b1, 32'h1000, 32'hBAAD_F00D, 4'hf, "st_range", 1'b0);
    access(1'b1, 32'h8000_0010, 32'hBAAD_F00D, 4'hf, "st_highbit", 1'b0);
    access(1'b0, 32'h0, 32'h0, 4'h0, "ld_w0", 1'b0);
    access(1'b0, 32'h10, 32'h0, 4'h0, "ld_noalias", 1'b0);
  endtask

  task automatic test_ignore_busy;
    access(1'b1, 32'h20, 32'h0102_0304, 4'hf, "st_w8", 1'b0);
    access(1'b0, 32'h10, 32'h0, 4'h0, "ld_intrude", 1'b1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b0) begin errors++; $display("FAIL extra_resp: resp_valid=%b required 0 at %0d", resp_valid, k); end
    end
    access(1'b0, 32'h20, 32'h0, 4'h0, "ld_w8", 1'b0);
  endtask

  task automatic test_reset_mid;
    access(1'b1, 32'h30, 32'h1234_5678, 4'hf, "st_w12", 1'b0);
    access(1'b0, 32'h30, 32'h0, 4'h0, "ld_w12_pre", 1'b0);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h30; req_wdata = 32'hCAFE_F00D; req_be = 4'hf;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, resp_valid, resp_err, resp_rdata} !== '0)
      begin errors++; $display("FAIL reset_mid: busy=%b valid=%b err=%b rdata=%h required all 0", busy, resp_valid, resp_err, resp_rdata); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_mid_valid: resp_valid=%b required 0", resp_valid); end
    end
    rst_n = 1'b1;
    access(1'b0, 32'h30, 32'h0, 4'h0, "ld_w12_post", 1'b0);
  endtask

  task automatic test_back_to_back;
    logic [32:0] got;
    @(negedge clk);
    z_req_valid = 1'b1; z_req_write = 1'b1; z_req_addr = 32'h40; z_req_wdata = 32'hA5A5_0F0F; z_req_be = 4'hf;
    @(negedge clk);
    checks++;
    if ({z_resp_valid, z_busy, z_resp_err} !== 3'b110)
      begin errors++; $display("FAIL z_store: valid=%b busy=%b err=%b required 1 1 0", z_resp_valid, z_busy, z_resp_err); end
    z_req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({z_resp_valid, z_busy} !== 2'b00)
      begin errors++; $display("FAIL z_idle: valid=%b busy=%b required 0 0", z_resp_valid, z_busy); end
    for (int k = 0; k < 4; k++) sb.push_back({1'b0, 32'hA5A5_0F0F});
    z_req_write = 1'b0; z_req_valid = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checks++;
      if ({z_resp_valid, z_busy} !== {2{k[0]}})
        begin errors++; $display("FAIL z_b2b_%0d: valid=%b busy=%b required %b %b", k, z_resp_valid, z_busy, k[0], k[0]); end
      if (z_resp_valid && sb.size() > 0) begin
        got = sb.pop_front();
        checks++;
        if ({z_resp_err, z_resp_rdata} !== got)
          begin errors++; $display("FAIL z_rdata_%0d: err=%b rdata=%h required %b %h", k, z_resp_err, z_resp_rdata, got[32], got[31:0]); end
      end
    end
    z_req_valid = 1'b0;
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL z_count: %0d responses missing required 0", sb.size()); end
    sb.delete();
  endtask

  initial begin
    checks = 0; errors = 0;
    test_reset;
    test_store_load;
    test_errors;
    test_ignore_busy;
    test_reset_mid;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
